// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter: core writeback vs buffered long-latency results
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   p_we, p_rd, p_wd            primary (core writeback) request, no handshake
//   s_valid, s_ready            secondary result handshake (s_ready = FIFO not full)
//   s_rd, s_wd                  secondary destination register and data
//   rf_we3, rf_a3, rf_wd3       register file write port
//   stall                       core must hold state and re-present its primary request
//   pend_mask                   one bit per register targeted by a live buffered result
//   fifo_count                  entries currently held in the FIFO
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_we,
  input  logic [4:0]  p_rd,
  input  logic [31:0] p_wd,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [4:0]  s_rd,
  input  logic [31:0] s_wd,
  output logic        rf_we3,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  output logic        stall,
  output logic [31:0] pend_mask,
  output logic [3:0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr, rd_ptr, count;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [4:0]       rd_q [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [DEPTH-1:0] valid_q, kill_q;
  logic [3:0]       starve_cnt;

  logic head_exists, live_head, drop_head;
  logic force_drain, prim_grant, sec_grant;
  logic push, pop;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  // Extra pointer bit: count reaches DEPTH (MSB set) only when full.
  assign count  = wr_ptr - rd_ptr;

  assign head_exists = valid_q[rd_idx];
  assign live_head   = head_exists && !kill_q[rd_idx];
  // A killed head leaves silently without touching the write port.
  assign drop_head   = head_exists && kill_q[rd_idx];

  assign force_drain = live_head && (starve_cnt == 4'(STARVE_MAX));
  assign prim_grant  = !force_drain && p_we && (p_rd != 5'd0);
  assign sec_grant   = !force_drain && !prim_grant && live_head;

  assign pop     = force_drain || sec_grant || drop_head;
  // Readiness depends on registered occupancy only; forced low during reset.
  assign s_ready = rst_n && !count[AW];
  assign push    = s_valid && s_ready;

  assign fifo_count = 4'(count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid_q    <= '0;
      kill_q     <= '0;
      starve_cnt <= '0;
    end else begin
      // A granted primary write is younger than anything buffered: kill WAW victims.
      for (int i = 0; i < DEPTH; i++) begin
        if (prim_grant && rd_q[i] == p_rd) kill_q[i] <= 1'b1;
      end
      if (pop) begin
        valid_q[rd_idx] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_ONE;
      end
      if (push) begin
        valid_q[wr_idx] <= 1'b1;
        kill_q[wr_idx]  <= (s_rd == 5'd0) || (prim_grant && s_rd == p_rd);
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (live_head && !pop) begin
        if (starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Payload storage needs no reset; valid_q qualifies every slot.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_idx] <= s_rd;
      wd_q[wr_idx] <= s_wd;
    end
  end

  always_comb begin
    rf_we3 = 1'b0;
    rf_a3  = 5'd0;
    rf_wd3 = 32'd0;
    stall  = 1'b0;
    if (rst_n) begin
      if (force_drain || sec_grant) begin
        rf_we3 = 1'b1;
        rf_a3  = rd_q[rd_idx];
        rf_wd3 = wd_q[rd_idx];
        stall  = force_drain;
      end else if (prim_grant) begin
        rf_we3 = 1'b1;
        rf_a3  = p_rd;
        rf_wd3 = p_wd;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !kill_q[i]) pend_mask[rd_q[i]] = 1'b1;
    end
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (we3/a3/wd3) between two sources.
- Primary source: the core's single-cycle writeback; it has no handshake and always wins by default.
- Secondary source: a long-latency unit (multiplier/divider/load return) with valid/ready handshake; its results are buffered in a small FIFO and drained into idle write-port cycles.
- A starvation counter forces a secondary drain by stalling the core, and a pending-register mask feeds hazard detection.

Parameters:
- DEPTH, 2, secondary FIFO entries (power of two, 2..8).
- STARVE_MAX, 4, consecutive cycles the FIFO head may wait before a forced drain (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p_we  in  1  primary write request this cycle.
- p_rd  in  5  primary destination register.
- p_wd  in  32  primary write data.
- s_valid  in  1  secondary result valid.
- s_ready  out  1  FIFO can accept (not full).
- s_rd  in  5  secondary destination register.
- s_wd  in  32  secondary write data.
- rf_we3  out  1  register file write enable.
- rf_a3  out  5  register file write address.
- rf_wd3  out  32  register file write data.
- stall  out  1  core must hold its state and primary inputs this cycle.
- pend_mask  out  32  bit i set when a live FIFO entry targets xi.
- fifo_count  out  4  number of entries in the FIFO (0..DEPTH).

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO is emptied, all entry valid/kill bits cleared, starvation counter = 0.
  - While rst_n is low: rf_we3=0, stall=0, s_ready=0, pend_mask=0, fifo_count=0.
  - Reset asserted mid-operation discards all buffered results.
- Push:
  - Push occurs when s_valid && s_ready.
  - s_ready = (fifo_count < DEPTH), taken from registered state only; it has no combinational path from s_valid.
  - An entry with s_rd==0 is accepted but stored killed (never written, not in pend_mask).
- Arbitration (combinational, evaluated each cycle; "head" = oldest live entry, killed entries at the head are popped silently, one per cycle, with no port use):
  - FORCE: the FIFO holds a live head and starve_cnt==STARVE_MAX.
    - Drive the head onto the port and pop it.
    - Assert stall=1; the primary request is not granted and must be re-presented next cycle unchanged.
  - PRIM: otherwise, if p_we && p_rd!=0, drive p_rd/p_wd onto the port. stall=0.
  - SEC: otherwise, if a live head exists, drive the head onto the port and pop it.
  - IDLE: otherwise rf_we3=0. rf_a3/rf_wd3 = 0.
  - p_we with p_rd==0 counts as an idle primary and never reaches the port.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle a live head exists and is not popped.
  - Clears on any secondary pop or when the FIFO becomes empty.
  - FORCE has the highest priority and therefore fires on the cycle the counter equals STARVE_MAX.
- WAW kill:
  - When PRIM grants register r, every live FIFO entry with rd==r is marked killed at the clock edge, since the primary write is younger.
  - An entry pushed in the same cycle with s_rd==r is also killed.
- Simultaneous push and pop:
  - Both are allowed in one cycle; fifo_count stays unchanged.
  - If full, s_ready=0, so no push occurs even if a pop happens that cycle.
- pend_mask:
  - OR over live entries of the one-hot rd; it comes from registered state, so it changes one cycle after push or kill.
  - An entry leaves the mask on the edge at which it is popped.
- Read/write pointers wrap modulo DEPTH. fifo_count is derived from an extra pointer bit.
- Latency:
  - The secondary result reaches the register file at the earliest one cycle after the push (written on the following edge).
  - The primary write is zero-latency (same cycle).

Test Plan:
- Primary-only: p_we=1, p_rd=5, p_wd=0xDEADBEEF, FIFO empty -> same cycle rf_we3=1, rf_a3=5, rf_wd3=0xDEADBEEF, stall=0.
- Idle drain: push s_rd=7, s_wd=0x12 with p_we=0 -> next cycle rf_we3=1, rf_a3=7, rf_wd3=0x12; pend_mask bit7 high for exactly one cycle, then fifo_count=0.
- Starvation: push s_rd=3 and hold p_we=1 (p_rd=9) continuously, STARVE_MAX=4 -> 4 cycles of primary grants, then one cycle with stall=1 and rf_a3=3; the primary is granted the next cycle.
- WAW kill: push s_rd=10; the next cycle primary writes p_rd=10 -> FIFO entry killed; x10 is written only by the primary; pend_mask bit10 clears; the port is never driven with a3=10 from the FIFO.
- Full/backpressure: hold p_we=1 and s_valid=1 for 3 pushes with DEPTH=2 -> s_ready=0 after 2 pushes; the third value is accepted only after a forced drain frees a slot; order of FIFO writes is preserved.
- Reset mid-operation: FIFO holding 2 entries, pull rst_n low asynchronously between edges -> rf_we3, stall, s_ready, pend_mask and fifo_count go to 0 immediately, and no buffered write occurs after release.
